// File: rtl/lock_timer_if.sv
// Request/grant bundle between the lock FSM and lock_timer_sched.
// Build option LOCK_TIMER_STATUS_EN adds mon_sel / mon_remaining.
interface lock_timer_if #(
  parameter int W = 16
);
  // Handshake: req[i] is a level held until ack[i]; ack[i] is a one-cycle grant
  // and the requester drops req[i] in that cycle. A req still high afterwards
  // is a fresh request. cancel[i] is a one-cycle abort pulse.
  logic [2:0]     req;
  logic [3*W-1:0] dur_ms;
  logic [2:0]     cancel;
  logic [2:0]     ack;
  logic [2:0]     busy;
  logic [2:0]     expire;
  logic           tick_ms;
`ifdef LOCK_TIMER_STATUS_EN
  logic [1:0]     mon_sel;
  logic [W-1:0]   mon_remaining;

  modport master (
    output req, dur_ms, cancel, mon_sel,
    input  ack, busy, expire, tick_ms, mon_remaining
  );
  modport slave (
    input  req, dur_ms, cancel, mon_sel,
    output ack, busy, expire, tick_ms, mon_remaining
  );
`else
  modport master (
    output req, dur_ms, cancel,
    input  ack, busy, expire, tick_ms
  );
  modport slave (
    input  req, dur_ms, cancel,
    output ack, busy, expire, tick_ms
  );
`endif
endinterface

// File: rtl/lock_timer_sched.sv
// Three-channel ms timer sharing one prescaler; fixed-priority grant ch2 > ch1 > ch0.
// Build option LOCK_TIMER_STATUS_EN adds a registered remaining-count monitor.
module lock_timer_sched #(
  parameter int TICK_DIV = 125000,
  parameter int W        = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  lock_timer_if.slave tif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [2:0]    grant;
  logic [2:0]    ack_q;
  logic [2:0]    busy_q, busy_d;
  logic [2:0]    exp_q, exp_d;
  logic [W-1:0]  rem_q [3];
  logic [W-1:0]  rem_d [3];

  // A channel being cancelled this cycle is not eligible; its req stays pending.
  always_comb begin
    logic [2:0] elig;
    elig  = tif.req & ~tif.cancel;
    grant = 3'b000;
    if (elig[2])      grant = 3'b100;
    else if (elig[1]) grant = 3'b010;
    else if (elig[0]) grant = 3'b001;
  end

  // Prescaler free-runs only while some channel is busy; parked at 0 otherwise.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (|busy_q) begin
      if (presc_q == PRESC_LAST) tick_d  = 1'b1;
      else                       presc_d = presc_q + PW'(1);
    end
  end

  // Per channel: cancel beats a load, a load beats the countdown.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rem_d[i]  = rem_q[i];
      busy_d[i] = busy_q[i];
      exp_d[i]  = 1'b0;
      if (tif.cancel[i]) begin
        rem_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else if (grant[i]) begin
        rem_d[i]  = tif.dur_ms[i*W +: W];
        busy_d[i] = |tif.dur_ms[i*W +: W];
        exp_d[i]  = ~|tif.dur_ms[i*W +: W];
      end else if (tick_q && busy_q[i]) begin
        if (rem_q[i] == W'(1)) begin
          rem_d[i]  = '0;
          busy_d[i] = 1'b0;
          exp_d[i]  = 1'b1;
        end else if (rem_q[i] != '0) begin
          rem_d[i] = rem_q[i] - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      ack_q   <= 3'b000;
      busy_q  <= 3'b000;
      exp_q   <= 3'b000;
      for (int i = 0; i < 3; i++) rem_q[i] <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      ack_q   <= grant;
      busy_q  <= busy_d;
      exp_q   <= exp_d;
      for (int i = 0; i < 3; i++) rem_q[i] <= rem_d[i];
    end
  end

  assign tif.ack     = ack_q;
  assign tif.busy    = busy_q;
  assign tif.expire  = exp_q;
  assign tif.tick_ms = tick_q;

`ifdef LOCK_TIMER_STATUS_EN
  logic [W-1:0] mon_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_q <= '0;
    end else begin
      case (tif.mon_sel)
        2'd0:    mon_q <= rem_q[0];
        2'd1:    mon_q <= rem_q[1];
        2'd2:    mon_q <= rem_q[2];
        default: mon_q <= '0;
      endcase
    end
  end

  assign tif.mon_remaining = mon_q;
`endif
endmodule
